sample_recorder: RTL and testbench
==================================

Name: sample_recorder

Overview:
- Captures live audio from input 0 into on-chip RAM while a record gate on input 1 is high.
- Replays the captured buffer on output 0 when input 2 receives a trigger.
- It is the writer counterpart of the sample player core and sits in the same slot: between the CODEC sample streams and the core mux.
- Everything runs in the single system clock domain. `sample_clk` is treated as a data strobe, not a clock.

Parameters:
- W, 16: sample width, signed two's complement.
- FP_OFFSET, 2: fixed-point shift. mV value v maps to v <<< FP_OFFSET.
- N_SAMPLES, 2048: buffer depth in samples. Must be a power of two, 16 or more.
- DECIMATE, 2: record and playback happen once every DECIMATE sample ticks. Range 1..255.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_clk  input  1  CODEC sample strobe, asynchronous to clk.
- sample_in0  input  W  audio to record (signed).
- sample_in1  input  W  record gate CV (signed).
- sample_in2  input  W  playback trigger CV (signed).
- sample_in3  input  W  unused; passed through.
- sample_out0  output  W  playback audio.
- sample_out1  output  W  monitor; combinational copy of sample_in0.
- sample_out2  output  W  REC status: FROM_MV(5000) while in REC, else 0.
- sample_out3  output  W  PLAY status: FROM_MV(5000) while in PLAY, else 0.
- jack  input  8  jack-detect bits; unused.

Behaviour:

Tick generation:
- sample_clk passes through a 2-flop synchronizer, then rising-edge detect.
- Result is `tick`, a one-clk pulse.
- All state changes, gate evaluation and RAM accesses happen only on clk cycles where tick=1.

Gate and trigger detection (inputs 1 and 2, evaluated on ticks):
- Schmitt comparator per input. Goes high when input ≥ FROM_MV(1000) (4000). Goes low when input < FROM_MV(500) (2000). Otherwise holds its level.
- A rising edge is a low-to-high transition between consecutive ticks.

Divider:
- `div` counts ticks modulo DECIMATE.
- An "action tick" is a tick with div==0.
- div clears to 0 on every state transition, so the first action occurs on the first tick after entry.

Buffer state:
- Registers: wr_ptr, rd_ptr, length. Each is clog2(N_SAMPLES)+1 bits.
- length is the number of valid samples, range 0..N_SAMPLES.

FSM states: IDLE, REC, PLAY.
- IDLE:
  - Rec-gate rising edge → REC; wr_ptr=0, length=0.
  - Else play-trigger rising edge with length>0 → PLAY; rd_ptr=0.
  - Play trigger with length==0 is ignored.
  - Rec and play edges on the same tick: REC wins.
- REC:
  - On each action tick: mem[wr_ptr] ← sample_in0; wr_ptr++; length ← wr_ptr+1.
  - Rec gate falls → IDLE; length is retained.
  - Write making length==N_SAMPLES (buffer full) → IDLE on that tick. No wrap-around. A new recording needs a fresh gate rising edge.
  - Play-trigger edges are ignored.
- PLAY:
  - On each action tick: RAM read address = rd_ptr; rd_ptr++.
  - Action tick with rd_ptr==length → IDLE; sample_out0 ← 0.
  - Play-trigger rising edge → rd_ptr=0 (retrigger restarts playback, stays in PLAY).
  - Rec-gate rising edge → abort playback, enter REC (same as the IDLE→REC transition).

RAM and output timing:
- Synchronous single-port RAM, N_SAMPLES×W, inferred as block RAM.
- Read data is registered into sample_out0 one clk after the RAM output. sample_out0 changes exactly 2 clk after the action tick.
- sample_out0 is 0 in IDLE and REC.
- sample_out2 and sample_out3 are registered. They update 1 clk after a state change.

Reset (any time, including mid-REC or mid-PLAY):
- State=IDLE; div, pointers and length = 0.
- Schmitt levels = low.
- sample_out0, sample_out2 and sample_out3 = 0.
- RAM contents are not cleared, but length=0 makes them unreachable.

Test Plan:
- Setup for all scenarios: N_SAMPLES=16, DECIMATE=2, sample_in0 = ramp 100,200,300… per tick.
- Basic record/play: in1=4000 for 8 ticks, then 0 → length=4, mem holding 100,300,500,700. in2 pulse to 4000 → out0 steps 100,300,500,700 on successive action ticks (each 2 clk after tick), then 0; out3 = 20000 during PLAY only.
- Overflow: hold in1=4000 for 40 ticks → exactly 16 writes, state returns to IDLE at the 16th write, out2 drops to 0 while the gate is still high, length=16.
- Hysteresis: in1 at 3000 → no REC. 4000 → REC. 2500 → still REC. 1999 → IDLE.
- Priority and retrigger: with length 4, raise in1 and in2 on the same tick → REC, no playback. Later, during PLAY, a second in2 edge after 2 samples → out0 restarts at mem[0].
- Empty and reset: in2 trigger after reset → out0 stays 0, state IDLE. Assert rst mid-PLAY → all outputs 0 asynchronously; a subsequent in2 trigger is ignored because length=0.

Source files
------------

// File: rtl/sample_recorder.sv
// rtl/sample_recorder.sv - gated audio capture into on-chip RAM with triggered replay
//
// Purpose: records sample_in0 into a RAM buffer while the record gate (sample_in1)
// is high, and replays the buffer on sample_out0 after a play trigger (sample_in2).
// All logic runs on clk; sample_clk is only sampled as a data strobe.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample_clk   CODEC sample strobe (asynchronous, synchronized here)
//   sample_in0   audio to record
//   sample_in1   record gate CV
//   sample_in2   playback trigger CV
//   sample_in3   unused
//   sample_out0  playback audio (registered)
//   sample_out1  monitor copy of sample_in0 (combinational)
//   sample_out2  REC status level (registered)
//   sample_out3  PLAY status level (registered)
//   jack         jack-detect bits, unused
module sample_recorder #(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int N_SAMPLES = 2048,
  parameter int DECIMATE  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  input  logic [7:0]   jack
);

  localparam int AW = $clog2(N_SAMPLES);
  localparam int PW = AW + 1;
  localparam logic signed [W-1:0] TH_HI     = W'(1000 << FP_OFFSET);
  localparam logic signed [W-1:0] TH_LO     = W'(500 << FP_OFFSET);
  localparam logic        [W-1:0] STATUS_ON = W'(5000 << FP_OFFSET);
  localparam logic        [7:0]   DIV_LAST  = 8'(DECIMATE - 1);

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  state_t         state;
  logic           sclk_s1, sclk_s2, sclk_s3;
  logic           tick;
  logic           gate_lvl, trig_lvl, gate_next, trig_next;
  logic           gate_rise, gate_fall, trig_rise;
  logic [7:0]     div;
  logic [7:0]     div_next;
  logic           action;
  logic [PW-1:0]  wr_ptr, rd_ptr, length;
  logic [PW-1:0]  wr_inc;
  logic           ram_we, ram_re, rd_pend;
  logic [AW-1:0]  ram_addr;
  logic [W-1:0]   ram_q;
  logic [W-1:0]   mem [N_SAMPLES];
  logic signed [W-1:0] in1_s, in2_s;
  logic           unused_ok;

  assign unused_ok   = ^{jack, sample_in3};
  assign sample_out1 = sample_in0;

  // Strobe synchronizer; the third flop only serves the rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
    end else begin
      sclk_s1 <= sample_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
    end
  end

  assign tick = sclk_s2 & ~sclk_s3;

  assign in1_s = $signed(sample_in1);
  assign in2_s = $signed(sample_in2);

  // Schmitt comparators: between the thresholds the previous level is held.
  always_comb begin
    gate_next = gate_lvl;
    trig_next = trig_lvl;
    if (in1_s >= TH_HI)     gate_next = 1'b1;
    else if (in1_s < TH_LO) gate_next = 1'b0;
    if (in2_s >= TH_HI)     trig_next = 1'b1;
    else if (in2_s < TH_LO) trig_next = 1'b0;
  end

  assign gate_rise = gate_next & ~gate_lvl;
  assign gate_fall = ~gate_next & gate_lvl;
  assign trig_rise = trig_next & ~trig_lvl;
  assign action    = (div == 8'd0);
  assign div_next  = (div >= DIV_LAST) ? 8'd0 : div + 8'd1;
  assign wr_inc    = wr_ptr + 1'b1;

  // RAM strobes mirror the FSM priorities below exactly.
  assign ram_we   = tick && (state == REC) && !gate_fall && action;
  assign ram_re   = tick && (state == PLAY) && !gate_rise && !trig_rise &&
                    action && (rd_ptr != length);
  assign ram_addr = (state == REC) ? wr_ptr[AW-1:0] : rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= sample_in0;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gate_lvl <= 1'b0;
      trig_lvl <= 1'b0;
      div      <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      length   <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= ram_re;
      if (tick) begin
        gate_lvl <= gate_next;
        trig_lvl <= trig_next;
        div      <= div_next;
        case (state)
          IDLE: begin
            if (gate_rise) begin
              state  <= REC;
              wr_ptr <= '0;
              length <= '0;
              div    <= 8'd0;
            end else if (trig_rise && length != '0) begin
              state  <= PLAY;
              rd_ptr <= '0;
              div    <= 8'd0;
            end
          end
          REC: begin
            if (gate_fall) begin
              state <= IDLE;
              div   <= 8'd0;
            end else if (action) begin
              wr_ptr <= wr_inc;
              length <= wr_inc;
              // Stop at full; no wrap, a new take needs a fresh gate edge.
              if (wr_inc == PW'(N_SAMPLES)) begin
                state <= IDLE;
                div   <= 8'd0;
              end
            end
          end
          PLAY: begin
            if (gate_rise) begin
              state  <= REC;
              wr_ptr <= '0;
              length <= '0;
              div    <= 8'd0;
            end else if (trig_rise) begin
              rd_ptr <= '0;
            end else if (action) begin
              if (rd_ptr == length) begin
                state <= IDLE;
                div   <= 8'd0;
              end else begin
                rd_ptr <= rd_ptr + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs trail the state register by one clk; audio is forced to 0 outside PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out0 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
    end else begin
      if (state != PLAY) sample_out0 <= '0;
      else if (rd_pend)  sample_out0 <= ram_q;
      sample_out2 <= (state == REC)  ? STATUS_ON : '0;
      sample_out3 <= (state == PLAY) ? STATUS_ON : '0;
    end
  end

endmodule

// File: tb/tb_sample_recorder.sv
// tb/tb_sample_recorder.sv - scoreboard bench for sample_recorder
module tb_sample_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_clk = 1'b0;
  logic [15:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
  logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic [7:0]  jack = '0;

  typedef struct {
    int    o0;
    int    o2;
    int    o3;
    string tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic [47:0] last_seen = '0;
  logic [15:0] lat0_o0, lat1_o0, lat0_o2, lat1_o2;

  sample_recorder #(.W(16), .FP_OFFSET(2), .N_SAMPLES(16), .DECIMATE(2)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3),
    .jack(jack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input int o0, input int o2, input int o3, input string tag);
    exp_t e;
    e.o0 = o0; e.o2 = o2; e.o3 = o3; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: every change of the observed outputs consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [47:0] cur;
      cur = {sample_out0, sample_out2, sample_out3};
      if (cur !== last_seen) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got out0=%0d out2=%0d out3=%0d expected no change",
                   sample_out0, sample_out2, sample_out3);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cur !== {16'(e.o0), 16'(e.o2), 16'(e.o3)}) begin
            n_bad++;
            $display("FAIL %s: got out0=%0d out2=%0d out3=%0d expected out0=%0d out2=%0d out3=%0d",
                     e.tag, sample_out0, sample_out2, sample_out3, e.o0, e.o2, e.o3);
          end
        end
        last_seen = cur;
      end
    end
  end

  // One sample strobe. The DUT acts on the 3rd clk edge after the strobe rises
  // and registered outputs move on the 4th; lat* capture out0/out2 around that.
  task automatic do_tick(input int v0, input int v1, input int v2);
    @(posedge clk); #1;
    sample_in0 = 16'(v0);
    sample_in1 = 16'(v1);
    sample_in2 = 16'(v2);
    sample_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lat0_o0 = sample_out0;
    lat0_o2 = sample_out2;
    @(negedge clk);
    lat1_o0 = sample_out0;
    lat1_o2 = sample_out2;
    repeat (2) @(posedge clk);
    #1 sample_clk = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string name);
    check(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample_in0 = 16'd1234;
    #1;
    check("reset_out0", sample_out0, 0);
    check("reset_out2", sample_out2, 0);
    check("reset_out3", sample_out3, 0);
    check("monitor_out1", sample_out1, 1234);
    sample_in0 = '0;
    last_seen = '0;
    mon_en = 1'b1;

    // Empty buffer: trigger ignored
    do_tick(0, 0, 4000);
    do_tick(0, 0, 0);
    do_tick(0, 0, 0);
    check("empty_trig_out3", sample_out3, 0);
    drain("drain_empty");

    // Hysteresis
    do_tick(0, 3000, 0);
    do_tick(0, 3000, 0);
    expect_out(0, 20000, 0, "hyst_enter_rec");
    do_tick(0, 4000, 0);
    do_tick(0, 2500, 0);
    do_tick(0, 2500, 0);
    do_tick(0, 2500, 0);
    expect_out(0, 0, 0, "hyst_leave_rec");
    do_tick(0, 1999, 0);
    drain("drain_hyst");

    // Basic record: writes land on odd ticks -> 100,300,500,700
    expect_out(0, 20000, 0, "basic_enter_rec");
    for (int k = 0; k < 8; k++) begin
      do_tick(100 * k, 4000, 0);
      if (k == 0) begin
        check("rec_status_before", lat0_o2, 0);
        check("rec_status_after", lat1_o2, 20000);
      end
    end
    expect_out(0, 0, 0, "basic_leave_rec");
    do_tick(800, 0, 0);
    expect_out(0, 0, 20000, "basic_enter_play");
    do_tick(900, 0, 4000);
    for (int t = 1; t <= 9; t++) begin
      if (t % 2 == 1 && t < 9) expect_out(100 * t, 0, 20000, $sformatf("basic_play_t%0d", t));
      if (t == 9) expect_out(0, 0, 0, "basic_play_end");
      do_tick(0, 0, 0);
      if (t == 1) begin
        check("play_latency_before", lat0_o0, 0);
        check("play_latency_after", lat1_o0, 100);
      end
    end
    drain("drain_basic");

    // Priority: gate and trigger rise together -> REC; records 1000,3000,5000,7000
    expect_out(0, 20000, 0, "prio_enter_rec");
    for (int k = 0; k < 8; k++) do_tick(1000 * k, 4000, 4000);
    expect_out(0, 0, 0, "prio_leave_rec");
    do_tick(0, 0, 0);
    drain("drain_prio");

    // Retrigger after two samples restarts at mem[0]
    expect_out(0, 0, 20000, "retrig_enter_play");
    do_tick(0, 0, 4000);
    expect_out(1000, 0, 20000, "retrig_s0");
    do_tick(0, 0, 0);
    do_tick(0, 0, 0);
    expect_out(3000, 0, 20000, "retrig_s1");
    do_tick(0, 0, 0);
    do_tick(0, 0, 4000);
    for (int t = 5; t <= 13; t++) begin
      if (t == 5)  expect_out(1000, 0, 20000, "retrig_restart_s0");
      if (t == 7)  expect_out(3000, 0, 20000, "retrig_restart_s1");
      if (t == 9)  expect_out(5000, 0, 20000, "retrig_restart_s2");
      if (t == 11) expect_out(7000, 0, 20000, "retrig_restart_s3");
      if (t == 13) expect_out(0, 0, 0, "retrig_end");
      do_tick(0, 0, 0);
    end
    drain("drain_retrig");

    // Abort playback by gate edge, then hold the gate into overflow
    expect_out(0, 0, 20000, "abort_enter_play");
    do_tick(0, 0, 4000);
    expect_out(1000, 0, 20000, "abort_s0");
    do_tick(0, 0, 0);
    expect_out(0, 20000, 0, "abort_to_rec");
    for (int k = 0; k < 40; k++) begin
      if (k == 31) expect_out(0, 0, 0, "overflow_full");
      do_tick(k == 0 ? 0 : 100 * k, 4000, 0);
    end
    do_tick(0, 0, 0);
    drain("drain_overflow");

    // Full-buffer playback: 16 samples 100,300,...,3100
    expect_out(0, 0, 20000, "full_enter_play");
    do_tick(0, 0, 4000);
    for (int t = 1; t <= 33; t++) begin
      if (t % 2 == 1 && t < 33) expect_out(100 * t, 0, 20000, $sformatf("full_play_t%0d", t));
      if (t == 33) expect_out(0, 0, 0, "full_play_end");
      do_tick(0, 0, 0);
    end
    drain("drain_full_play");

    // Reset mid-PLAY clears outputs asynchronously; later trigger is ignored
    expect_out(0, 0, 20000, "rst_enter_play");
    do_tick(0, 0, 4000);
    expect_out(100, 0, 20000, "rst_s0");
    do_tick(0, 0, 0);
    expect_out(0, 0, 0, "rst_clear");
    @(posedge clk); #1 rst = 1'b1;
    #2;
    check("async_rst_out0", sample_out0, 0);
    check("async_rst_out2", sample_out2, 0);
    check("async_rst_out3", sample_out3, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_tick(0, 0, 0);
    do_tick(0, 0, 4000);
    do_tick(0, 0, 0);
    do_tick(0, 0, 0);
    check("post_rst_trig_out3", sample_out3, 0);
    drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
